// File: rtl/neuron_accumulator.sv
// Sequential dot-product accumulator: multiplies 1/5/6 float pairs and sums them
// into a 1/6/12 accumulator, emitting the result when the InLast pair retires.
module neuron_accumulator #(
    parameter int unsigned BIAS_IN  = 15,
    parameter int unsigned BIAS_ACC = 31
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        InValid,
    output logic        InReady,
    input  logic        InLast,
    input  logic        InSignA,
    input  logic [4:0]  InExpA,
    input  logic [5:0]  InManA,
    input  logic        InSignB,
    input  logic [4:0]  InExpB,
    input  logic [5:0]  InManB,
    output logic        OutValid,
    output logic        Sign,
    output logic [5:0]  Exponent,
    output logic [11:0] Mantissa
);

    localparam int unsigned EW_IN  = 5;
    localparam int unsigned MW_IN  = 6;
    localparam int unsigned EW_ACC = 6;
    localparam int unsigned MW_ACC = 12;
    localparam int unsigned SW     = MW_ACC + 1;
    localparam int unsigned PW     = 2 * (MW_IN + 1);
    localparam int unsigned EPW    = 8;

    localparam logic [EW_ACC-1:0] EXP_MAX = '1;
    localparam logic [EPW-1:0]    EP_MAX  = EPW'(EXP_MAX);
    // Modular 8-bit offset; a negative BIAS_ACC - 2*BIAS_IN wraps to its two's complement.
    localparam logic [EPW-1:0]    EP_OFS  = EPW'(BIAS_ACC - 2 * BIAS_IN);

    typedef enum logic [2:0] {IDLE, MUL, ALIGN, ADD, NORM, DONE} state_t;

    state_t state;

    logic              op_sa, op_sb, last_q;
    logic [EW_IN-1:0]  op_ea, op_eb;
    logic [MW_IN-1:0]  op_ma, op_mb;

    logic              prod_s, prod_zero;
    logic [EW_ACC-1:0] prod_e;
    logic [SW-1:0]     prod_sig;

    logic              big_s, small_s;
    logic [EW_ACC-1:0] big_e;
    logic [SW-1:0]     big_sig, small_sig;

    // Accumulator keeps the hidden bit explicitly; zero is sig == 0 with S=0, E=0.
    logic              acc_s;
    logic [EW_ACC-1:0] acc_e;
    logic [SW-1:0]     acc_sig;

    logic [PW-1:0]     mul_full;
    logic [EPW-1:0]    mul_ep, mul_epn;
    logic [MW_ACC-1:0] mul_m;
    logic              mul_zero, mul_sat;

    // Product of the captured operands, normalised to [1,2).
    always_comb begin
        mul_full = PW'({1'b1, op_ma}) * PW'({1'b1, op_mb});
        mul_ep   = EPW'(op_ea) + EPW'(op_eb) + EP_OFS;
        mul_m    = mul_full[MW_ACC-1:0];
        mul_epn  = mul_ep;
        if (mul_full[PW-1]) begin
            mul_m   = mul_full[PW-2 -: MW_ACC];
            mul_epn = mul_ep + EPW'(1);
        end
        mul_zero = (op_ea == '0 && op_ma == '0) || (op_eb == '0 && op_mb == '0) ||
                   mul_epn[EPW-1];
        mul_sat  = !mul_epn[EPW-1] && (mul_epn > EP_MAX);
    end

    logic              acc_big;
    logic [EW_ACC-1:0] al_diff;
    logic [SW-1:0]     al_small, al_shift;

    // Pick the larger magnitude and right-shift the other by the exponent gap.
    always_comb begin
        acc_big = {acc_e, acc_sig} >= {prod_e, prod_sig};
        if (acc_big) begin
            al_diff  = acc_e - prod_e;
            al_small = prod_sig;
        end else begin
            al_diff  = prod_e - acc_e;
            al_small = acc_sig;
        end
        al_shift = (al_diff >= EW_ACC'(SW)) ? '0 : (al_small >> al_diff);
    end

    logic [SW:0]       ad_sum;
    logic [SW-1:0]     ad_dif;
    logic              ad_s;
    logic [EW_ACC-1:0] ad_e;
    logic [SW-1:0]     ad_sig;

    // Signed-magnitude add; carry at the top exponent saturates.
    always_comb begin
        ad_sum = {1'b0, big_sig} + {1'b0, small_sig};
        ad_dif = big_sig - small_sig;
        ad_s   = big_s;
        ad_e   = big_e;
        ad_sig = ad_sum[SW-1:0];
        if (big_s == small_s) begin
            if (ad_sum[SW]) begin
                if (big_e == EXP_MAX) begin
                    ad_sig = '1;
                end else begin
                    ad_e   = big_e + EW_ACC'(1);
                    ad_sig = ad_sum[SW:1];
                end
            end
        end else if (ad_dif == '0) begin
            ad_s   = 1'b0;
            ad_e   = '0;
            ad_sig = '0;
        end else begin
            ad_sig = ad_dif;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            InReady   <= 1'b0;
            OutValid  <= 1'b0;
            Sign      <= 1'b0;
            Exponent  <= '0;
            Mantissa  <= '0;
            op_sa     <= 1'b0;
            op_sb     <= 1'b0;
            op_ea     <= '0;
            op_eb     <= '0;
            op_ma     <= '0;
            op_mb     <= '0;
            last_q    <= 1'b0;
            prod_s    <= 1'b0;
            prod_zero <= 1'b1;
            prod_e    <= '0;
            prod_sig  <= '0;
            big_s     <= 1'b0;
            small_s   <= 1'b0;
            big_e     <= '0;
            big_sig   <= '0;
            small_sig <= '0;
            acc_s     <= 1'b0;
            acc_e     <= '0;
            acc_sig   <= '0;
        end else begin
            OutValid <= 1'b0;
            case (state)
                IDLE: begin
                    InReady <= 1'b1;
                    if (InValid && InReady) begin
                        op_sa   <= InSignA;
                        op_ea   <= InExpA;
                        op_ma   <= InManA;
                        op_sb   <= InSignB;
                        op_eb   <= InExpB;
                        op_mb   <= InManB;
                        last_q  <= InLast;
                        InReady <= 1'b0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    prod_zero <= mul_zero;
                    if (mul_zero) begin
                        prod_s   <= 1'b0;
                        prod_e   <= '0;
                        prod_sig <= '0;
                    end else if (mul_sat) begin
                        prod_s   <= op_sa ^ op_sb;
                        prod_e   <= EXP_MAX;
                        prod_sig <= '1;
                    end else begin
                        prod_s   <= op_sa ^ op_sb;
                        prod_e   <= mul_epn[EW_ACC-1:0];
                        prod_sig <= {1'b1, mul_m};
                    end
                    state <= ALIGN;
                end
                ALIGN: begin
                    big_s     <= acc_big ? acc_s : prod_s;
                    big_e     <= acc_big ? acc_e : prod_e;
                    big_sig   <= acc_big ? acc_sig : prod_sig;
                    small_s   <= acc_big ? prod_s : acc_s;
                    small_sig <= al_shift;
                    state     <= ADD;
                end
                ADD: begin
                    if (!prod_zero) begin
                        acc_s   <= ad_s;
                        acc_e   <= ad_e;
                        acc_sig <= ad_sig;
                    end
                    state <= NORM;
                end
                NORM: begin
                    if (acc_sig == '0 || acc_sig[SW-1] || acc_e == '0) begin
                        // Unnormalised at exponent 0 would underflow: flush to +0.
                        if (acc_sig != '0 && !acc_sig[SW-1]) begin
                            acc_s   <= 1'b0;
                            acc_e   <= '0;
                            acc_sig <= '0;
                        end
                        if (last_q) begin
                            state <= DONE;
                        end else begin
                            state   <= IDLE;
                            InReady <= 1'b1;
                        end
                    end else begin
                        acc_sig <= acc_sig << 1;
                        acc_e   <= acc_e - EW_ACC'(1);
                    end
                end
                DONE: begin
                    Sign     <= acc_s;
                    Exponent <= acc_e;
                    Mantissa <= acc_sig[MW_ACC-1:0];
                    OutValid <= 1'b1;
                    acc_s    <= 1'b0;
                    acc_e    <= '0;
                    acc_sig  <= '0;
                    InReady  <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    InReady <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: results are scoreboarded against
// hand-derived expectations, plus handshake latency and reset behaviour.
module tb_neuron_accumulator;

    localparam int BOUND = 60;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic        sa, sb;
    logic [4:0]  ea, eb;
    logic [5:0]  ma, mb;
    logic        out_valid, sgn;
    logic [5:0]  expo;
    logic [11:0] mant;

    typedef struct packed {
        logic        s;
        logic [5:0]  e;
        logic [11:0] m;
    } res_t;

    res_t exp_q[$];
    res_t mon_w;
    int   checks    = 0;
    int   errors    = 0;
    int   out_count = 0;
    int   out_before;

    neuron_accumulator #(.BIAS_IN(15), .BIAS_ACC(31)) dut (
        .Clock    (clk),
        .Resetn   (rst_n),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .InLast   (in_last),
        .InSignA  (sa),
        .InExpA   (ea),
        .InManA   (ma),
        .InSignB  (sb),
        .InExpB   (eb),
        .InManB   (mb),
        .OutValid (out_valid),
        .Sign     (sgn),
        .Exponent (expo),
        .Mantissa (mant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic push(input logic s, input logic [5:0] e, input logic [11:0] m);
        res_t r;
        r.s = s;
        r.e = e;
        r.m = m;
        exp_q.push_back(r);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic s_a, input logic [4:0] e_a, input logic [5:0] m_a,
                        input logic s_b, input logic [4:0] e_b, input logic [5:0] m_b,
                        input logic last);
        int n = 0;
        while (in_ready !== 1'b1 && n < BOUND) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        assert (n < BOUND) else begin
            errors++;
            $error("FAIL ready_timeout: observed=%0d cycles expected<%0d", n, BOUND);
        end
        sa = s_a; ea = e_a; ma = m_a;
        sb = s_b; eb = e_b; mb = m_b;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int want);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (in_ready !== 1'b1 && n < BOUND);
        chk(tag, 32'(n), 32'(want));
    endtask

    task automatic wait_out(input string tag, input int want);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (out_valid !== 1'b1 && n < BOUND);
        chk(tag, 32'(n), 32'(want));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(out_valid), 32'(0));
    endtask

    // Scoreboard: every OutValid pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            out_count++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_out: observed=OutValid expected=no pulse");
            end
            if (exp_q.size() > 0) begin
                mon_w = exp_q.pop_front();
                chk("result", 32'({sgn, expo, mant}), 32'(mon_w));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        sa = 1'b0; ea = '0; ma = '0; sb = 1'b0; eb = '0; mb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'(0));
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_sign", 32'(sgn), 32'(0));
        chk("rst_exp", 32'(expo), 32'(0));
        chk("rst_man", 32'(mant), 32'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'(1));

        // 1.0 x 1.0 single-element vector
        push(1'b0, 6'd31, 12'h000);
        send(1'b0, 5'd15, 6'd0, 1'b0, 5'd15, 6'd0, 1'b1);
        wait_out("one_lat", 5);

        // two 1.0 products; output must hold while the vector runs
        send(1'b0, 5'd15, 6'd0, 1'b0, 5'd15, 6'd0, 1'b0);
        wait_ready("pair_ready", 4);
        chk("hold_exp", 32'(expo), 32'(31));
        chk("hold_man", 32'(mant), 32'(0));
        push(1'b0, 6'd32, 12'h000);
        send(1'b0, 5'd15, 6'd0, 1'b0, 5'd15, 6'd0, 1'b1);
        wait_out("two_lat", 5);

        // exact cancellation
        send(1'b0, 5'd15, 6'd0, 1'b0, 5'd15, 6'd0, 1'b0);
        wait_ready("cancel_ready", 4);
        push(1'b0, 6'd0, 12'h000);
        send(1'b1, 5'd15, 6'd0, 1'b0, 5'd15, 6'd0, 1'b1);
        wait_out("cancel_lat", 5);

        // 1.5 x 1.5 = 2.25, then saturating exponent
        push(1'b0, 6'd32, 12'h200);
        send(1'b0, 5'd15, 6'h20, 1'b0, 5'd15, 6'h20, 1'b1);
        wait_out("sq_lat", 5);
        push(1'b0, 6'd63, 12'hFFF);
        send(1'b0, 5'd31, 6'h20, 1'b0, 5'd31, 6'h20, 1'b1);
        wait_out("sat_lat", 5);

        // zero operand leaves the accumulator at +0
        send(1'b0, 5'd0, 6'd0, 1'b0, 5'd15, 6'd0, 1'b0);
        wait_ready("zero_ready", 4);
        push(1'b0, 6'd0, 12'h000);
        send(1'b0, 5'd15, 6'd0, 1'b0, 5'd0, 6'd0, 1'b1);
        wait_out("zero_lat", 5);

        // 1.5 - 1.25 = 0.25 needs two normalise shifts
        send(1'b0, 5'd15, 6'h20, 1'b0, 5'd15, 6'd0, 1'b0);
        wait_ready("norm_a_ready", 4);
        send(1'b1, 5'd15, 6'h10, 1'b0, 5'd15, 6'd0, 1'b0);
        wait_ready("norm2_ready", 6);
        push(1'b0, 6'd29, 12'h000);
        send(1'b0, 5'd0, 6'd0, 1'b0, 5'd15, 6'd0, 1'b1);
        wait_out("norm2_lat", 5);

        // negative product
        push(1'b1, 6'd31, 12'h000);
        send(1'b1, 5'd15, 6'd0, 1'b0, 5'd15, 6'd0, 1'b1);
        wait_out("neg_lat", 5);

        // alignment gap 13 drops the addend, gap 12 keeps its lsb
        send(1'b0, 5'd15, 6'd0, 1'b0, 5'd15, 6'd0, 1'b0);
        wait_ready("gap13_ready", 4);
        push(1'b0, 6'd31, 12'h000);
        send(1'b0, 5'd2, 6'd0, 1'b0, 5'd15, 6'd0, 1'b1);
        wait_out("gap13_lat", 5);
        send(1'b0, 5'd15, 6'd0, 1'b0, 5'd15, 6'd0, 1'b0);
        wait_ready("gap12_ready", 4);
        push(1'b0, 6'd31, 12'h001);
        send(1'b0, 5'd3, 6'd0, 1'b0, 5'd15, 6'd0, 1'b1);
        wait_out("gap12_lat", 5);

        // carry out of the top exponent saturates
        send(1'b0, 5'd31, 6'h20, 1'b0, 5'd31, 6'h20, 1'b0);
        wait_ready("satadd_ready", 4);
        push(1'b0, 6'd63, 12'hFFF);
        send(1'b0, 5'd31, 6'h20, 1'b0, 5'd31, 6'h20, 1'b1);
        wait_out("satadd_lat", 5);

        // 1.0 + (-2.0): larger operand's sign wins, one shift
        send(1'b0, 5'd15, 6'd0, 1'b0, 5'd15, 6'd0, 1'b0);
        wait_ready("bigsign_ready", 4);
        push(1'b1, 6'd31, 12'h000);
        send(1'b1, 5'd16, 6'd0, 1'b0, 5'd15, 6'd0, 1'b1);
        wait_out("bigsign_lat", 6);

        // reset while the first pair of a vector is in NORM
        out_before = out_count;
        send(1'b0, 5'd15, 6'd0, 1'b0, 5'd15, 6'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(in_ready), 32'(0));
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_exp", 32'(expo), 32'(0));
        chk("midrst_sign", 32'(sgn), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready_back", 32'(in_ready), 32'(1));
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_out", 32'(out_count), 32'(out_before));
        push(1'b0, 6'd31, 12'h000);
        send(1'b0, 5'd15, 6'd0, 1'b0, 5'd15, 6'd0, 1'b1);
        wait_out("fresh_lat", 5);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_accumulator.md
NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 SHALL have parameter BIAS_IN, default 15: exponent bias of the 1/5/6 operand format.
REQ-002 SHALL have parameter BIAS_ACC, default 31: exponent bias of the 1/6/12 accumulator format.
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports InValid input 1, InReady output 1, InLast input 1: operand handshake; InLast marks the final pair of a vector.
REQ-006 SHALL have ports InSignA input 1, InExpA input 5, InManA input 6: activation operand.
REQ-007 SHALL have ports InSignB input 1, InExpB input 5, InManB input 6: weight operand.
REQ-008 SHALL have ports OutValid output 1, Sign output 1, Exponent output 6, Mantissa output 12: dot-product result in the format consumed by the ReLU stage.

Function
REQ-009 SHALL interpret values as (-1)^S x 1.M x 2^(E-bias); E=0 and M=0 together encode zero; all other codes are normal numbers, with no denormals, infinities or NaN.
REQ-010 SHALL implement FSM states IDLE, MUL, ALIGN, ADD, NORM and DONE.
REQ-011 SHALL assert InReady only in IDLE; a pair is accepted when InValid and InReady are both high on a rising edge, and operands and InLast are captured then.
REQ-012 SHALL perform MUL in one cycle:
  - product sign = InSignA XOR InSignB;
  - EP = InExpA + InExpB - 2*BIAS_IN + BIAS_ACC, computed 8 bits wide;
  - significand = (1.MA) x (1.MB), 14 bits;
  - if significand >= 2: shift right 1 and EP+1;
  - keep the top 12 fraction bits, truncated.
REQ-013 SHALL treat a product as zero if either operand is zero; the accumulator is then unchanged but the pair still traverses the FSM.
REQ-014 SHALL saturate a product with EP > 63 to exponent 63, mantissa 12'hFFF, keeping the product sign.
REQ-015 SHALL perform ALIGN in one cycle: shift the smaller-magnitude operand right by the exponent difference, truncated; a difference >= 13 makes its contribution zero.
REQ-016 SHALL perform ADD in one cycle:
  - same signs: add magnitudes; on carry-out shift right 1 and exponent+1, saturating as in REQ-014;
  - different signs: subtract the smaller magnitude from the larger; the result takes the larger operand's sign;
  - exact cancellation gives +0 (S=0, E=0, M=0).
REQ-017 SHALL perform NORM with one left shift and exponent-1 per cycle until the hidden bit is set (0..12 cycles); if the exponent would drop below 0, flush the accumulator to +0.
REQ-018 SHALL return from NORM to IDLE when InLast was clear, or go to DONE when it was set.
REQ-019 SHALL, in DONE:
  - load Sign/Exponent/Mantissa from the accumulator;
  - pulse OutValid high for exactly one cycle;
  - clear the accumulator to +0;
  - return to IDLE.
REQ-020 SHALL hold Sign/Exponent/Mantissa stable between OutValid pulses.
REQ-021 SHALL have per-pair latency of 4 + NORM cycles from acceptance back to InReady; result latency is 5 + NORM cycles from acceptance of the InLast pair to OutValid.
REQ-022 SHALL treat a single pair with InLast set as a one-element vector.

Reset
REQ-023 SHALL, while Resetn is low, force: FSM=IDLE, accumulator=+0, InReady=0, OutValid=0, Sign=0, Exponent=0, Mantissa=0.
REQ-024 SHALL drive InReady=1 on the first rising edge after Resetn deasserts.
REQ-025 SHALL, on a mid-operation reset, discard any partial accumulation and produce no OutValid for the aborted vector.

Verification
REQ-026 SHALL pass: pair (S0,E15,M0)x(S0,E15,M0) with InLast -> OutValid pulse; Sign=0, Exponent=31, Mantissa=12'h000.
REQ-027 SHALL pass: two pairs 1.0x1.0, the second with InLast -> Sign=0, Exponent=32, Mantissa=12'h000.
REQ-028 SHALL pass: 1.0x1.0 then (S1,E15,M0)x(S0,E15,M0) with InLast -> Sign=0, Exponent=0, Mantissa=0.
REQ-029 SHALL pass: (S0,E15,M6'b100000)x(same) with InLast -> Exponent=32, Mantissa=12'h200; with E31 on both operands instead -> Exponent=63, Mantissa=12'hFFF.
REQ-030 SHALL pass: zero operand x 1.0 with InLast -> +0 result; InReady is low for exactly 4 cycles after acceptance.
REQ-031 SHALL pass: Resetn pulsed low during NORM of the first pair of a two-pair vector -> no OutValid; a fresh 1.0x1.0 with InLast -> Exponent=31.
